// File: rtl/pard_reset_seq.sv
// pard_reset_seq: reset and bring-up sequencer for the pardcore subsystem.
// Releases the uncore, then the cores, after power-up. At run time it turns
// MMIO soft-reset requests into per-core reset pulses or a full re-bring-up.
// Before any reset it blocks new memory traffic and waits for the memory port
// to drain, giving up after a bounded number of cycles.

module pard_reset_seq #(
    parameter int NR_CORES      = 2,
    parameter int UNCORE_HOLD   = 16,
    parameter int CORE_HOLD     = 64,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                uncoreclk,
    input  logic                uncore_rstn,
    input  logic                sys_rst_req,
    input  logic [NR_CORES-1:0] core_rst_req,
    input  logic [NR_CORES-1:0] core_hold,
    input  logic                mem_idle,
    input  logic                err_clr,
    output logic                uncorerstn_out,
    output logic [NR_CORES-1:0] corerstn,
    output logic                jtag_trst,
    output logic                mem_block,
    output logic                busy,
    output logic [2:0]          state,
    output logic                timeout_err
);

    // One counter serves all three timed phases, so it is sized for the
    // longest of them.
    localparam int MAX_AB  = (UNCORE_HOLD > CORE_HOLD) ? UNCORE_HOLD : CORE_HOLD;
    localparam int MAX_ALL = (MAX_AB > DRAIN_TIMEOUT) ? MAX_AB : DRAIN_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] UNC_LAST   = CNT_W'(UNCORE_HOLD - 1);
    localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_ALL - 1);

    typedef enum logic [2:0] {
        RST_ALL   = 3'd0,
        UNC_WAIT  = 3'd1,
        CORE_WAIT = 3'd2,
        RUN       = 3'd3,
        DRAIN     = 3'd4,
        PULSE     = 3'd5
    } seq_state_t;

    seq_state_t          cur_state;
    logic [CNT_W-1:0]    cnt;
    logic [NR_CORES-1:0] pend_mask;
    logic [NR_CORES-1:0] snap_mask;
    logic                sys_pend;

    logic [NR_CORES-1:0] req_mask;
    logic                sys_any;
    logic [CNT_W-1:0]    cnt_inc;
    logic                unc_done;
    logic                core_done;
    logic                drain_exit;
    logic                drain_timeout;

    // Requests seen this cycle are merged with the stored ones so that a pulse
    // arriving on the same edge as a state decision is acted on, not dropped.
    always_comb begin
        req_mask      = pend_mask | core_rst_req;
        sys_any       = sys_pend | sys_rst_req;
        cnt_inc       = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        unc_done      = (cnt == UNC_LAST);
        core_done     = (cnt == CORE_LAST);
        drain_timeout = !mem_idle && (cnt == DRAIN_LAST);
        drain_exit    = mem_idle || (cnt == DRAIN_LAST);
    end

    // Sequencer FSM: owns the counter, the request bookkeeping and every reset
    // output, so each output changes on exactly the edge its transition happens.
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            cur_state      <= RST_ALL;
            cnt            <= '0;
            pend_mask      <= '0;
            snap_mask      <= '0;
            sys_pend       <= 1'b0;
            uncorerstn_out <= 1'b0;
            corerstn       <= '0;
            jtag_trst      <= 1'b1;
            mem_block      <= 1'b1;
            busy           <= 1'b1;
        end else begin
            pend_mask <= req_mask;
            sys_pend  <= sys_any;
            case (cur_state)
                RST_ALL: begin
                    cnt            <= '0;
                    uncorerstn_out <= 1'b0;
                    corerstn       <= '0;
                    jtag_trst      <= 1'b1;
                    mem_block      <= 1'b1;
                    busy           <= 1'b1;
                    cur_state      <= UNC_WAIT;
                end
                UNC_WAIT: begin
                    if (unc_done) begin
                        cnt            <= '0;
                        uncorerstn_out <= 1'b1;
                        jtag_trst      <= 1'b0;
                        cur_state      <= CORE_WAIT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                CORE_WAIT: begin
                    if (core_done) begin
                        cnt       <= '0;
                        corerstn  <= ~core_hold;
                        mem_block <= 1'b0;
                        busy      <= 1'b0;
                        cur_state <= RUN;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    corerstn <= ~core_hold;
                    if ((req_mask != '0) || sys_any) begin
                        snap_mask <= req_mask;
                        pend_mask <= '0;
                        cnt       <= '0;
                        mem_block <= 1'b1;
                        busy      <= 1'b1;
                        cur_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    corerstn <= ~core_hold;
                    if (drain_exit) begin
                        cnt <= '0;
                        if (sys_any) begin
                            // A full reset supersedes every outstanding core request.
                            pend_mask      <= '0;
                            snap_mask      <= '0;
                            sys_pend       <= 1'b0;
                            uncorerstn_out <= 1'b0;
                            corerstn       <= '0;
                            jtag_trst      <= 1'b1;
                            cur_state      <= RST_ALL;
                        end else begin
                            corerstn  <= ~core_hold & ~snap_mask;
                            cur_state <= PULSE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PULSE: begin
                    if (core_done) begin
                        cnt       <= '0;
                        snap_mask <= '0;
                        corerstn  <= ~core_hold;
                        mem_block <= 1'b0;
                        busy      <= 1'b0;
                        cur_state <= RUN;
                    end else begin
                        corerstn <= ~core_hold & ~snap_mask;
                        cnt      <= cnt_inc;
                    end
                end
                default: begin
                    cur_state <= RST_ALL;
                end
            endcase
        end
    end

    // Sticky drain-timeout flag; a new timeout outranks a simultaneous clear.
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            timeout_err <= 1'b0;
        end else if ((cur_state == DRAIN) && drain_timeout) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pard_reset_seq.sv
// tb_pard_reset_seq: scoreboard bench for pard_reset_seq. Stimulus tasks
// predict each change of the reset outputs (value and cycle) from the
// sequencing rules and queue it; a monitor pops one prediction per observed
// output change.

module tb_pard_reset_seq;

    localparam int UH = 16;
    localparam int CH = 64;
    localparam int DT = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sys_rst_req = 1'b0;
    logic [1:0] core_rst_req = 2'b00;
    logic [1:0] core_hold = 2'b00;
    logic       mem_idle = 1'b1;
    logic       err_clr = 1'b0;

    logic       uncorerstn_out;
    logic [1:0] corerstn;
    logic       jtag_trst;
    logic       mem_block;
    logic       busy;
    logic [2:0] state;
    logic       timeout_err;

    typedef struct packed {
        logic       unc;
        logic [1:0] core;
        logic       jtag;
        logic       mb;
        logic       bsy;
        logic       terr;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ev_t;

    ev_t  exp_q[$];
    obs_t exp_cur;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    pard_reset_seq #(
        .NR_CORES(2), .UNCORE_HOLD(UH), .CORE_HOLD(CH), .DRAIN_TIMEOUT(DT)
    ) dut (
        .uncoreclk(clk),
        .uncore_rstn(rst_n),
        .sys_rst_req(sys_rst_req),
        .core_rst_req(core_rst_req),
        .core_hold(core_hold),
        .mem_idle(mem_idle),
        .err_clr(err_clr),
        .uncorerstn_out(uncorerstn_out),
        .corerstn(corerstn),
        .jtag_trst(jtag_trst),
        .mem_block(mem_block),
        .busy(busy),
        .state(state),
        .timeout_err(timeout_err)
    );

    // Free-running clock and an edge counter used as the scoreboard timebase.
    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic unc, input logic [1:0] core,
                                input logic jtag, input logic mb,
                                input logic bsy, input logic terr);
        obs_t o;
        o.unc  = unc;
        o.core = core;
        o.jtag = jtag;
        o.mb   = mb;
        o.bsy  = bsy;
        o.terr = terr;
        return o;
    endfunction

    function automatic obs_t sample_outputs();
        return mk(uncorerstn_out, corerstn, jtag_trst, mem_block, busy, timeout_err);
    endfunction

    // Queue a predicted output change; a prediction equal to the current value
    // is not a visible change and is dropped.
    task automatic expect_at(input int at, input obs_t o);
        ev_t e;
        if (o != exp_cur) begin
            e.cyc = at;
            e.o   = o;
            exp_q.push_back(e);
            exp_cur = o;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) @(negedge clk);
    endtask

    // Full bring-up starting with the edge that entered (or left) RST_ALL.
    task automatic push_bringup(input int r);
        logic t;
        t = exp_cur.terr;
        expect_at(r + 1 + UH, mk(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, t));
        expect_at(r + 1 + UH + CH, mk(1'b1, ~core_hold, 1'b0, 1'b0, 1'b0, t));
    endtask

    task automatic apply_hold(input logic [1:0] h);
        int c;
        c = cyc;
        core_hold = h;
        expect_at(c + 1, mk(1'b1, ~h, 1'b0, 1'b0, 1'b0, exp_cur.terr));
        @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        int c;
        c = cyc;
        err_clr = 1'b1;
        expect_at(c + 1, mk(exp_cur.unc, exp_cur.core, exp_cur.jtag, exp_cur.mb, exp_cur.bsy, 1'b0));
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Core soft reset where mem_idle is first seen high on the k-th drain cycle;
    // k beyond the drain limit means the drain times out.
    task automatic apply_stimulus(input logic [1:0] m, input int k, input bit clr_same);
        int c, e;
        logic t;
        logic [1:0] h;
        c = cyc;
        h = core_hold;
        t = exp_cur.terr;
        mem_idle = (k == 1);
        core_rst_req = m;
        expect_at(c + 1, mk(1'b1, ~h, 1'b0, 1'b1, 1'b1, t));
        e = c + 1 + ((k > DT) ? DT : k);
        if (k > DT) t = 1'b1;
        expect_at(e, mk(1'b1, ~h & ~m, 1'b0, 1'b1, 1'b1, t));
        expect_at(e + CH, mk(1'b1, ~h, 1'b0, 1'b0, 1'b0, t));
        @(negedge clk);
        core_rst_req = 2'b00;
        if (k > 1 && k <= DT) begin
            wait_until(c + k);
            mem_idle = 1'b1;
        end
        if (clr_same) begin
            wait_until(e - 1);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        wait_until(e + CH + 2);
        mem_idle = 1'b1;
        check_output("state_run_after_pulse", 32'(state), 32'd3);
    endtask

    // System request (optionally together with core requests) issued in RUN.
    task automatic run_sys_req(input logic [1:0] m, input int k);
        int c, r;
        c = cyc;
        mem_idle = (k == 1);
        sys_rst_req = 1'b1;
        core_rst_req = m;
        expect_at(c + 1, mk(1'b1, ~core_hold, 1'b0, 1'b1, 1'b1, exp_cur.terr));
        r = c + 1 + k;
        expect_at(r, mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, exp_cur.terr));
        push_bringup(r);
        @(negedge clk);
        sys_rst_req = 1'b0;
        core_rst_req = 2'b00;
        if (k > 1) begin
            wait_until(c + k);
            mem_idle = 1'b1;
        end
        wait_until(r + UH + CH + 6);
        check_output("state_run_after_sys", 32'(state), 32'd3);
    endtask

    // A request arriving during a core pulse: sys or a second core request.
    task automatic req_during_pulse(input logic [1:0] m, input bit is_sys, input logic [1:0] m2);
        int c, e, s;
        logic t;
        logic [1:0] h;
        c = cyc;
        h = core_hold;
        t = exp_cur.terr;
        mem_idle = 1'b1;
        core_rst_req = m;
        e = c + 2;
        expect_at(c + 1, mk(1'b1, ~h, 1'b0, 1'b1, 1'b1, t));
        expect_at(e, mk(1'b1, ~h & ~m, 1'b0, 1'b1, 1'b1, t));
        expect_at(e + CH, mk(1'b1, ~h, 1'b0, 1'b0, 1'b0, t));
        expect_at(e + CH + 1, mk(1'b1, ~h, 1'b0, 1'b1, 1'b1, t));
        if (is_sys) begin
            expect_at(e + CH + 2, mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, t));
            push_bringup(e + CH + 2);
        end else begin
            expect_at(e + CH + 2, mk(1'b1, ~h & ~m2, 1'b0, 1'b1, 1'b1, t));
            expect_at(e + CH + 2 + CH, mk(1'b1, ~h, 1'b0, 1'b0, 1'b0, t));
        end
        @(negedge clk);
        core_rst_req = 2'b00;
        s = e + $urandom_range(1, CH - 2);
        wait_until(s);
        if (is_sys) sys_rst_req = 1'b1;
        else core_rst_req = m2;
        @(negedge clk);
        sys_rst_req = 1'b0;
        core_rst_req = 2'b00;
        wait_until(e + CH + 2 + UH + CH + 6);
        check_output("state_run_after_nested", 32'(state), 32'd3);
    endtask

    // Async reset while draining, with extra requests left pending.
    task automatic reset_mid_drain(input logic [1:0] m);
        int c, x;
        c = cyc;
        mem_idle = 1'b0;
        core_rst_req = m;
        expect_at(c + 1, mk(1'b1, ~core_hold, 1'b0, 1'b1, 1'b1, exp_cur.terr));
        @(negedge clk);
        core_rst_req = 2'b00;
        sys_rst_req = 1'b1;
        @(negedge clk);
        sys_rst_req = 1'b0;
        core_rst_req = ~m;
        @(negedge clk);
        core_rst_req = 2'b00;
        wait_until(c + 3 + $urandom_range(1, 40));
        #2;
        x = cyc;
        expect_at(x + 1, mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0));
        rst_n = 1'b0;
        #1;
        check_output("async_unc", 32'(uncorerstn_out), 32'd0);
        check_output("async_core", 32'(corerstn), 32'd0);
        check_output("async_jtag", 32'(jtag_trst), 32'd1);
        check_output("async_mb", 32'(mem_block), 32'd1);
        check_output("async_busy", 32'(busy), 32'd1);
        check_output("async_terr", 32'(timeout_err), 32'd0);
        check_output("async_state", 32'(state), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        x = cyc;
        push_bringup(x);
        wait_until(x + UH + CH + 20);
        mem_idle = 1'b1;
        check_output("state_run_after_async", 32'(state), 32'd3);
    endtask

    // Monitor: every change of the observed outputs must match the next
    // prediction in both value and cycle.
    initial begin
        obs_t prev, cur;
        ev_t  e;
        prev = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        forever begin
            @(negedge clk);
            cur = sample_outputs();
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_change cyc %0d: got %b, none expected", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.o !== cur || e.cyc != cyc) begin
                        errors++;
                        $display("[TB] FAIL output_event: got %b at cyc %0d, expected %b at cyc %0d",
                                 cur, cyc, e.o, e.cyc);
                    end
                end
            end
            prev = cur;
        end
    end

    // Main stimulus sequence.
    initial begin
        int c0, k;
        logic [1:0] m;
        exp_cur = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_output("reset_state", 32'(state), 32'd0);
        check_output("reset_outputs", 32'(sample_outputs()), 32'(exp_cur));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        push_bringup(c0);
        wait_until(c0 + UH + CH + 4);
        check_output("powerup_state", 32'(state), 32'd3);
        check_output("powerup_core", 32'(corerstn), 32'd3);

        for (int i = 0; i < 6; i++) begin
            apply_hold(2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        apply_hold(2'b10);
        apply_hold(2'b00);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            apply_hold(2'($urandom_range(0, 3)));
            repeat (2) @(negedge clk);
            m = 2'($urandom_range(1, 3));
            k = ($urandom_range(0, 1) == 0) ? 1 : $urandom_range(2, 30);
            apply_stimulus(m, k, 1'b0);
        end
        apply_hold(2'b00);
        repeat (2) @(negedge clk);

        apply_stimulus(2'b01, DT - 1, 1'b0);
        apply_stimulus(2'b10, DT, 1'b0);
        apply_stimulus(2'b01, DT + 76, 1'b0);
        check_output("terr_sticky", 32'(timeout_err), 32'd1);
        repeat (5) @(negedge clk);
        pulse_err_clr();
        repeat (2) @(negedge clk);
        apply_stimulus(2'b11, DT + 10, 1'b1);

        req_during_pulse(2'b01, 1'b1, 2'b00);
        req_during_pulse(2'b01, 1'b0, 2'b10);
        run_sys_req(2'b11, 1);
        run_sys_req(2'b00, $urandom_range(2, 20));

        apply_hold(2'b01);
        repeat (2) @(negedge clk);
        reset_mid_drain(2'b10);
        apply_hold(2'b00);

        repeat (20) @(negedge clk);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
